// File: rtl/mux_scan_sel.sv
// Registered N-to-1 channel selector with two modes. Manual mode registers in[sel].
// Auto-scan mode walks the enabled channels in ch_mask and holds each one for DWELL
// cycles. Every output is registered.
module mux_scan_sel #(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned DW    = 1,
  parameter int unsigned DWELL = 4,
  localparam int unsigned SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*DW-1:0] in,
  input  logic [SW-1:0]     sel,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [DW-1:0]     out,
  output logic [SW-1:0]     out_ch,
  output logic              out_valid,
  output logic              wrap
);

  typedef enum logic [0:0] {StMan, StScan} state_e;

  state_e         state_q;
  logic [SW-1:0]  scan_ch_q;
  logic [7:0]     dwell_cnt_q;

  // Out-of-range indices return zero rather than reading past the bus.
  function automatic logic [DW-1:0] pick(input logic [N_CH*DW-1:0] bus,
                                         input logic [SW-1:0]      idx);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx == SW'(i)) r = bus[i*DW +: DW];
    end
    return r;
  endfunction

  logic          sel_ok;
  logic [SW-1:0] first_ch;
  logic          any_en;
  logic [SW-1:0] above_ch;
  logic          above_found;
  logic [SW-1:0] nxt_ch;
  logic          nxt_wraps;
  logic          hold_ch;

  // Priority scans: lowest enabled channel, and lowest enabled channel above scan_ch_q.
  always_comb begin
    sel_ok      = 1'b0;
    first_ch    = '0;
    any_en      = 1'b0;
    above_ch    = '0;
    above_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (sel == SW'(i)) sel_ok = 1'b1;
      if (ch_mask[i]) begin
        first_ch = SW'(i);
        any_en   = 1'b1;
        if (SW'(i) > scan_ch_q) begin
          above_ch    = SW'(i);
          above_found = 1'b1;
        end
      end
    end
    nxt_ch    = above_found ? above_ch : first_ch;
    nxt_wraps = !above_found;
    hold_ch   = (dwell_cnt_q < 8'(DWELL)) && ch_mask[scan_ch_q];
  end

  // Mode FSM plus registered outputs; mode is sampled at every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StMan;
      scan_ch_q   <= '0;
      dwell_cnt_q <= '0;
      out         <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (!mode) begin
        state_q   <= StMan;
        out       <= sel_ok ? pick(in, sel) : '0;
        out_ch    <= sel;
        out_valid <= sel_ok;
      end else if (state_q == StMan) begin
        // Entry edge: always restart at the lowest enabled channel.
        state_q <= StScan;
        if (any_en) begin
          scan_ch_q   <= first_ch;
          dwell_cnt_q <= 8'd1;
          out         <= pick(in, first_ch);
          out_ch      <= first_ch;
          out_valid   <= 1'b1;
        end else begin
          out       <= '0;
          out_valid <= 1'b0;
        end
      end else if (!any_en) begin
        // Nothing enabled: park with scan position held.
        out       <= '0;
        out_valid <= 1'b0;
      end else if (hold_ch) begin
        dwell_cnt_q <= dwell_cnt_q + 8'd1;
        out         <= pick(in, scan_ch_q);
        out_ch      <= scan_ch_q;
        out_valid   <= 1'b1;
      end else begin
        scan_ch_q   <= nxt_ch;
        dwell_cnt_q <= 8'd1;
        out         <= pick(in, nxt_ch);
        out_ch      <= nxt_ch;
        out_valid   <= 1'b1;
        wrap        <= nxt_wraps;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: a 16-channel DWELL=3 instance and a 12-channel one.
module tb_mux_scan_sel;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in = 64'hFEDCBA9876543210;
  logic [3:0]  sel;
  logic        mode;
  logic [15:0] ch_mask;
  logic [3:0]  out;
  logic [3:0]  out_ch;
  logic        out_valid;
  logic        wrap;

  logic [47:0] in2 = 48'hBA9876543210;
  logic [3:0]  sel2;
  logic        mode2;
  logic [11:0] ch_mask2;
  logic [3:0]  out2;
  logic [3:0]  out_ch2;
  logic        out_valid2;
  logic        wrap2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_scan_sel #(.N_CH(16), .DW(4), .DWELL(3)) dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .mode(mode), .ch_mask(ch_mask),
    .out(out), .out_ch(out_ch), .out_valid(out_valid), .wrap(wrap)
  );

  mux_scan_sel #(.N_CH(12), .DW(4), .DWELL(3)) dut12 (
    .clk(clk), .rst(rst), .in(in2), .sel(sel2), .mode(mode2), .ch_mask(ch_mask2),
    .out(out2), .out_ch(out_ch2), .out_valid(out_valid2), .wrap(wrap2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 4'd5; ch_mask = 16'h0000;
    mode2 = 1'b0; sel2 = 4'd3; ch_mask2 = 12'h000;
    tick(); tick();
    tests++; if (out !== 4'd0) begin fails++; $display("FAIL reset_out got %0h exp 0", out); end
    tests++; if (out_ch !== 4'd0) begin fails++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b exp 0", wrap); end
    tests++; if (out_valid2 !== 1'b0) begin fails++; $display("FAIL reset_valid12 got %b exp 0", out_valid2); end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    mode = 1'b0; sel = 4'd6;
    tick();
    tests++; if (out !== 4'h6) begin fails++; $display("FAIL man6_out got %0h exp 6", out); end
    tests++; if (out_ch !== 4'd6) begin fails++; $display("FAIL man6_ch got %0d exp 6", out_ch); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL man6_valid got %b exp 1", out_valid); end
    sel = 4'd12;
    tick();
    tests++; if (out !== 4'hC) begin fails++; $display("FAIL man12_out got %0h exp c", out); end
    tests++; if (out_ch !== 4'd12) begin fails++; $display("FAIL man12_ch got %0d exp 12", out_ch); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_ch [10] = '{4'd0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd0};
    ch_mask = 16'h0111; mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests++;
      if (out_ch !== exp_ch[k] || out !== exp_ch[k] || out_valid !== 1'b1 ||
          wrap !== (k == 9)) begin
        fails++;
        $display("FAIL scan_step%0d got ch=%0d out=%0h v=%b w=%b exp ch=%0d out=%0h v=1 w=%b",
                 k, out_ch, out, out_valid, wrap, exp_ch[k], exp_ch[k], (k == 9));
      end
    end
  endtask

  // Continues from the scan left at channel 0 with dwell 1.
  task automatic test_mask_clear();
    tick(); tick(); tick();
    tests++; if (out_ch !== 4'd4) begin fails++; $display("FAIL clr_on4 got %0d exp 4", out_ch); end
    tick();
    ch_mask = 16'h0101;
    tick();
    tests++; if (out_ch !== 4'd8 || wrap !== 1'b0) begin
      fails++; $display("FAIL clr_skip got ch=%0d w=%b exp ch=8 w=0", out_ch, wrap);
    end
    tick(); tick();
    tests++; if (out_ch !== 4'd8) begin fails++; $display("FAIL clr_dwell got %0d exp 8", out_ch); end
    tick();
    tests++; if (out_ch !== 4'd0 || wrap !== 1'b1) begin
      fails++; $display("FAIL clr_wrap got ch=%0d w=%b exp ch=0 w=1", out_ch, wrap);
    end
    ch_mask = 16'h0000;
    tick();
    tests++; if (out_valid !== 1'b0 || out !== 4'd0 || wrap !== 1'b0) begin
      fails++; $display("FAIL empty got v=%b out=%0h w=%b exp v=0 out=0 w=0", out_valid, out, wrap);
    end
    ch_mask = 16'h0010;
    tick();
    tests++; if (out_ch !== 4'd4 || out !== 4'h4 || out_valid !== 1'b1 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL refill got ch=%0d out=%0h v=%b w=%b exp ch=4 out=4 v=1 w=0",
               out_ch, out, out_valid, wrap);
    end
  endtask

  task automatic test_alt_config();
    sel2 = 4'd13;
    tick();
    tests++; if (out_valid2 !== 1'b0 || out2 !== 4'd0) begin
      fails++; $display("FAIL alt13 got v=%b out=%0h exp v=0 out=0", out_valid2, out2);
    end
    tests++; if (out_ch2 !== 4'd13) begin fails++; $display("FAIL alt13_ch got %0d exp 13", out_ch2); end
    sel2 = 4'd11;
    tick();
    tests++; if (out_valid2 !== 1'b1 || out2 !== 4'hB || out_ch2 !== 4'd11) begin
      fails++; $display("FAIL alt11 got v=%b out=%0h ch=%0d exp v=1 out=b ch=11",
                        out_valid2, out2, out_ch2);
    end
  endtask

  task automatic test_reset_mid_scan();
    ch_mask = 16'h0111; mode = 1'b0; sel = 4'd2;
    tick();
    mode = 1'b1;
    tick();
    tests++; if (out_ch !== 4'd0) begin fails++; $display("FAIL rescan_entry got %0d exp 0", out_ch); end
    tick(); tick(); tick();
    tests++; if (out_ch !== 4'd4) begin fails++; $display("FAIL mid_on4 got %0d exp 4", out_ch); end
    rst = 1'b1;
    tick();
    tests++; if (out !== 4'd0 || out_ch !== 4'd0 || out_valid !== 1'b0 || wrap !== 1'b0) begin
      fails++; $display("FAIL mid_rst got out=%0h ch=%0d v=%b w=%b exp all 0",
                        out, out_ch, out_valid, wrap);
    end
    rst = 1'b0;
    tick();
    tests++; if (out_ch !== 4'd0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL post_rst got ch=%0d v=%b exp ch=0 v=1", out_ch, out_valid);
    end
    tick();
    tests++; if (out_ch !== 4'd0) begin fails++; $display("FAIL post_rst_dwell got %0d exp 0", out_ch); end
  endtask

  task automatic test_single_channel();
    logic exp_w [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ch_mask = 16'h0100; mode = 1'b0;
    tick();
    mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      tests++;
      if (out_ch !== 4'd8 || out !== 4'h8 || wrap !== exp_w[k]) begin
        fails++;
        $display("FAIL single%0d got ch=%0d out=%0h w=%b exp ch=8 out=8 w=%b",
                 k, out_ch, out, wrap, exp_w[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_mask_clear();
    test_alt_config();
    test_reset_mid_scan();
    test_single_channel();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
